// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALU op encodings,
// requester ids and response entry layout helpers.
package alu_share_arbiter_pkg;

   // ALU operation encodings; ALU_XXX marks an illegal/unsupported op
   localparam logic [3:0] ALU_ADD   = 4'h0;
   localparam logic [3:0] ALU_SUB   = 4'h1;
   localparam logic [3:0] ALU_AND   = 4'h2;
   localparam logic [3:0] ALU_OR    = 4'h3;
   localparam logic [3:0] ALU_XOR   = 4'h4;
   localparam logic [3:0] ALU_SLL   = 4'h5;
   localparam logic [3:0] ALU_SRL   = 4'h6;
   localparam logic [3:0] ALU_SRA   = 4'h7;
   localparam logic [3:0] ALU_SLT   = 4'h8;
   localparam logic [3:0] ALU_SLTU  = 4'h9;
   localparam logic [3:0] ALU_COPYB = 4'hA;
   localparam logic [3:0] ALU_XXX   = 4'hF;

   // Requester identifiers carried back with each response
   localparam logic ARB_ID_REQ0 = 1'b0;
   localparam logic ARB_ID_REQ1 = 1'b1;

   // Response entry side-band widths (id and error flag)
   localparam int RESP_ID_W  = 1;
   localparam int RESP_ERR_W = 1;

   // Total stored entry width: {data, id, tag, err}
   function automatic int resp_entry_w(input int xlen, input int tag_w);
      return xlen + tag_w + RESP_ID_W + RESP_ERR_W;
   endfunction

   // True when the op cannot be executed and must return an error response
   function automatic logic is_illegal_op(input logic [3:0] op);
      return (op == ALU_XXX);
   endfunction

endpackage

// File: rtl/alu_share_arbiter_resp_fifo.sv
// Response FIFO for the ALU share arbiter: circular buffer with
// wrap-around head/tail pointers and an occupancy counter. A push and a
// pop in the same cycle leave the count unchanged.
module alu_resp_fifo
   import alu_share_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 38
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;

   assign w_pop   = o_valid & i_ready;
   assign o_valid = (r_count != {CNT_W{1'b0}});
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_data  = r_mem[r_head];

   // Storage, pointers and occupancy; reset discards every in-flight entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
         r_head  <= {PTR_W{1'b0}};
         r_tail  <= {PTR_W{1'b0}};
         r_count <= {CNT_W{1'b0}};
      end else begin
         if (i_push) begin
            r_mem[r_tail] <= i_data;
            r_tail        <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters and
// queues results in a small response FIFO. Contention is round-robin by
// default; defining ALU_ARB_FIXED_PRIO_EN makes req0 always win and
// removes the round-robin pointer.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int TAG_W      = 4,
   parameter int RESP_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [XLEN-1:0]  req0_a,
   input  logic [XLEN-1:0]  req0_b,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [XLEN-1:0]  req1_a,
   input  logic [XLEN-1:0]  req1_b,
   input  logic [TAG_W-1:0] req1_tag,
   output logic [3:0]       alu_op,
   output logic [XLEN-1:0]  alu_a,
   output logic [XLEN-1:0]  alu_b,
   input  logic [XLEN-1:0]  alu_result,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_data,
   output logic             resp_id,
   output logic [TAG_W-1:0] resp_tag,
   output logic             resp_err
);

   localparam int ENTRY_W = resp_entry_w(XLEN, TAG_W);

   logic               w_space;
   logic               w_fifo_full;
   logic               w_grant0;
   logic               w_grant1;
   logic               w_push;
   logic               w_err;
   logic [TAG_W-1:0]   w_tag;
   logic [ENTRY_W-1:0] w_entry;
   logic [ENTRY_W-1:0] w_head;

   // A pop in this cycle frees a slot for a new accept in the same cycle
   assign w_space = !w_fifo_full || (resp_valid && resp_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Fixed priority: req0 wins any contention, req1 only when req0 is idle
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (w_space) begin
         w_grant0 = req0_valid;
         w_grant1 = req1_valid && !req0_valid;
      end else begin
         w_grant0 = 1'b0;
         w_grant1 = 1'b0;
      end
   end
`else
   logic r_rr_ptr;

   // Round-robin: a lone requester always wins, contention goes to r_rr_ptr
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (!w_space) begin
         w_grant0 = 1'b0;
         w_grant1 = 1'b0;
      end else if (req0_valid && req1_valid) begin
         w_grant0 = (r_rr_ptr == ARB_ID_REQ0);
         w_grant1 = (r_rr_ptr == ARB_ID_REQ1);
      end else begin
         w_grant0 = req0_valid;
         w_grant1 = req1_valid;
      end
   end

   // Pointer moves to the loser only after a contended grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= ARB_ID_REQ0;
      end else if (req0_valid && req1_valid && (w_grant0 || w_grant1)) begin
         r_rr_ptr <= w_grant0 ? ARB_ID_REQ1 : ARB_ID_REQ0;
      end else begin
         r_rr_ptr <= r_rr_ptr;
      end
   end
`endif

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;
   assign w_push     = w_grant0 || w_grant1;

   // Steer the shared ALU; req0 drives it whenever req1 is not granted
   always_comb begin
      alu_op = req0_op;
      alu_a  = req0_a;
      alu_b  = req0_b;
      w_tag  = req0_tag;
      if (w_grant1) begin
         alu_op = req1_op;
         alu_a  = req1_a;
         alu_b  = req1_b;
         w_tag  = req1_tag;
      end else begin
         alu_op = req0_op;
         alu_a  = req0_a;
         alu_b  = req0_b;
         w_tag  = req0_tag;
      end
   end

   // Illegal ops are stored with zero data and the error flag set
   assign w_err   = is_illegal_op(alu_op);
   assign w_entry = {(w_err ? {XLEN{1'b0}} : alu_result),
                     (w_grant1 ? ARB_ID_REQ1 : ARB_ID_REQ0),
                     w_tag,
                     w_err};

   alu_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_resp_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_entry),
      .o_full  (w_fifo_full),
      .o_valid (resp_valid),
      .i_ready (resp_ready),
      .o_data  (w_head)
   );

   assign resp_data = w_head[ENTRY_W-1:TAG_W+2];
   assign resp_id   = w_head[TAG_W+1];
   assign resp_tag  = w_head[TAG_W:1];
   assign resp_err  = w_head[0];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios followed
// by randomized traffic, all compared against a queue-based reference
// model. Build with +define+ALU_ARB_FIXED_PRIO_EN to check the
// fixed-priority variant.
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   localparam int XLEN  = 32;
   localparam int TAG_W = 4;
   localparam int DEPTH = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]       req0_op, req1_op, alu_op;
   logic [XLEN-1:0]  req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
   logic [TAG_W-1:0] req0_tag, req1_tag, resp_tag;
   logic             resp_valid, resp_ready, resp_id, resp_err;
   logic [XLEN-1:0]  resp_data;

   alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W), .RESP_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_id(resp_id), .resp_tag(resp_tag), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   // Behavioural shared ALU
   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_ADD:   return a + b;
         ALU_SUB:   return a - b;
         ALU_AND:   return a & b;
         ALU_OR:    return a | b;
         ALU_XOR:   return a ^ b;
         ALU_SLL:   return a << b[4:0];
         ALU_SRL:   return a >> b[4:0];
         ALU_SRA:   return 32'($signed(a) >>> b[4:0]);
         ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
         ALU_COPYB: return b;
         default:   return 32'hDEAD_BEEF;
      endcase
   endfunction

   always_comb alu_result = alu_ref(alu_op, alu_a, alu_b);

   typedef struct packed {
      logic [31:0] data;
      logic        id;
      logic [3:0]  tag;
      logic        err;
   } resp_t;

   resp_t q[$];        // expected responses, oldest first
   int    favour = 0;  // requester that wins the next contention
   int    tests  = 0;
   int    fails  = 0;

   task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
      end
   endtask

   function automatic logic [3:0] rand_op();
      int r;
      r = $urandom_range(0, 11);
      return (r == 11) ? ALU_XXX : 4'(r);
   endfunction

   // One clock cycle: inputs already driven at the preceding negedge
   task automatic step(input string nm, output logic o_r0, output logic o_r1,
                       output logic e_g0, output logic e_g1);
      logic  rv, space, g0, g1;
      resp_t e;
      #1;
      rv    = (q.size() > 0);
      space = (q.size() < DEPTH) || (rv && resp_ready);
      g0 = 1'b0;
      g1 = 1'b0;
      if (space) begin
         if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            g0 = 1'b1;
`else
            if (favour == 0) g0 = 1'b1;
            else             g1 = 1'b1;
`endif
         end else begin
            g0 = req0_valid;
            g1 = req1_valid;
         end
      end
      o_r0 = req0_ready;
      o_r1 = req1_ready;
      check($sformatf("%s.rdy0", nm), 64'(req0_ready), 64'(g0));
      check($sformatf("%s.rdy1", nm), 64'(req1_ready), 64'(g1));
      e = '0;
      if (g0) begin
         check($sformatf("%s.alu_op", nm), 64'(alu_op), 64'(req0_op));
         check($sformatf("%s.alu_a", nm), 64'(alu_a), 64'(req0_a));
         e.err  = (req0_op == ALU_XXX);
         e.data = e.err ? 32'd0 : alu_ref(req0_op, req0_a, req0_b);
         e.id   = 1'b0;
         e.tag  = req0_tag;
      end
      if (g1) begin
         check($sformatf("%s.alu_op", nm), 64'(alu_op), 64'(req1_op));
         check($sformatf("%s.alu_b", nm), 64'(alu_b), 64'(req1_b));
         e.err  = (req1_op == ALU_XXX);
         e.data = e.err ? 32'd0 : alu_ref(req1_op, req1_a, req1_b);
         e.id   = 1'b1;
         e.tag  = req1_tag;
      end
      @(posedge clk);
      if (rv && resp_ready) q.delete(0);
      if (g0 || g1) q.push_back(e);
`ifndef ALU_ARB_FIXED_PRIO_EN
      if (req0_valid && req1_valid && (g0 || g1)) favour = g0 ? 1 : 0;
`endif
      #1;
      check($sformatf("%s.resp_valid", nm), 64'(resp_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
         check($sformatf("%s.resp_data", nm), 64'(resp_data), 64'(q[0].data));
         check($sformatf("%s.resp_id", nm), 64'(resp_id), 64'(q[0].id));
         check($sformatf("%s.resp_tag", nm), 64'(resp_tag), 64'(q[0].tag));
         check($sformatf("%s.resp_err", nm), 64'(resp_err), 64'(q[0].err));
      end
      @(negedge clk);
      e_g0 = g0;
      e_g1 = g1;
   endtask

   initial begin
      logic r0, r1, g0, g1, last0, last1, exp0;
      int   acc;

      rst = 1'b1;
      req0_valid = 1'b0; req0_op = ALU_ADD; req0_a = '0; req0_b = '0; req0_tag = '0;
      req1_valid = 1'b0; req1_op = ALU_ADD; req1_a = '0; req1_b = '0; req1_tag = '0;
      resp_ready = 1'b0;
      #12;
      check("reset.resp_valid", 64'(resp_valid), 64'd0);
      check("reset.resp_data", 64'(resp_data), 64'd0);
      check("reset.resp_id", 64'(resp_id), 64'd0);
      check("reset.resp_tag", 64'(resp_tag), 64'd0);
      check("reset.resp_err", 64'(resp_err), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single requester ADD 5+7
      req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd5; req0_b = 32'd7; req0_tag = 4'd3;
      resp_ready = 1'b1;
      step("single", r0, r1, g0, g1);
      check("single.ready", 64'(r0), 64'd1);
      check("single.data", 64'(resp_data), 64'd12);
      check("single.id", 64'(resp_id), 64'd0);
      check("single.tag", 64'(resp_tag), 64'd3);
      check("single.valid", 64'(resp_valid), 64'd1);
      req0_valid = 1'b0;

      // Contention for four cycles
      req0_valid = 1'b1; req0_op = ALU_SUB; req0_a = 32'd100; req0_b = 32'd1; req0_tag = 4'd1;
      req1_valid = 1'b1; req1_op = ALU_XOR; req1_a = 32'hF0F0; req1_b = 32'h0FF0; req1_tag = 4'd2;
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp0 = 1'b1;
`else
         exp0 = (i % 2 == 0);
`endif
         step($sformatf("contend%0d", i), r0, r1, g0, g1);
         check($sformatf("contend%0d.g0", i), 64'(r0), 64'(exp0));
         check($sformatf("contend%0d.g1", i), 64'(r1), 64'(!exp0));
      end

      // Backpressure: drain, then stall with both requesting
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i < 3; i++) step("drain_a", r0, r1, g0, g1);
      resp_ready = 1'b0;
      req0_valid = 1'b1; req0_op = ALU_OR; req0_a = 32'h10; req0_b = 32'h01; req0_tag = 4'd4;
      req1_valid = 1'b1; req1_op = ALU_SLL; req1_a = 32'h3; req1_b = 32'd4; req1_tag = 4'd5;
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         step("bp_stall", r0, r1, g0, g1);
         acc += int'(r0) + int'(r1);
      end
      check("bp.accepts", 64'(acc), 64'd2);
      check("bp.ready_low", 64'(r0 | r1), 64'd0);
      resp_ready = 1'b1;
      step("bp_pop", r0, r1, g0, g1);
      check("bp.pop_accept", 64'(r0 | r1), 64'd1);
      resp_ready = 1'b0;
      step("bp_full", r0, r1, g0, g1);
      check("bp.full_ready", 64'(r0 | r1), 64'd0);
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) step("drain_b", r0, r1, g0, g1);

      // Illegal op from requester 1
      req1_valid = 1'b1; req1_op = ALU_XXX; req1_a = 32'h1234; req1_b = 32'h5678; req1_tag = 4'd9;
      step("illegal", r0, r1, g0, g1);
      check("illegal.ready", 64'(r1), 64'd1);
      check("illegal.err", 64'(resp_err), 64'd1);
      check("illegal.data", 64'(resp_data), 64'd0);
      check("illegal.id", 64'(resp_id), 64'd1);
      check("illegal.tag", 64'(resp_tag), 64'd9);
      req1_valid = 1'b0;
      step("idle", r0, r1, g0, g1);

      // Reset mid-stream with two entries queued and the pointer favouring req1
`ifndef ALU_ARB_FIXED_PRIO_EN
      req0_valid = 1'b1; req1_valid = 1'b1; req1_op = ALU_ADD;
      for (int k = 0; k < 3 && favour != 1; k++) step("pre_rst", r0, r1, g0, g1);
      check("pre_rst.favour", 64'(favour), 64'd1);
`endif
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i < 3; i++) step("drain_c", r0, r1, g0, g1);
      resp_ready = 1'b0;
      req0_valid = 1'b1; req0_op = ALU_AND; req0_a = 32'hFF; req0_b = 32'h0F; req0_tag = 4'd6;
      step("fill0", r0, r1, g0, g1);
      step("fill1", r0, r1, g0, g1);
      check("fill.count", 64'(q.size()), 64'd2);
      req0_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_async.valid", 64'(resp_valid), 64'd0);
      check("rst_async.data", 64'(resp_data), 64'd0);
      q.delete();
      favour = 0;
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
      step("post_rst", r0, r1, g0, g1);
      check("post_rst.g0", 64'(r0), 64'd1);
      check("post_rst.g1", 64'(r1), 64'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Randomized traffic; a requester holds its op until it is accepted
      last0 = 1'b1; last1 = 1'b1;
      for (int c = 0; c < 400; c++) begin
         resp_ready = ($urandom_range(0, 3) != 0);
         if (!req0_valid || last0) begin
            req0_valid = 1'($urandom_range(0, 1));
            req0_op = rand_op(); req0_a = $urandom; req0_b = $urandom;
            req0_tag = 4'($urandom_range(0, 15));
         end
         if (!req1_valid || last1) begin
            req1_valid = 1'($urandom_range(0, 1));
            req1_op = rand_op(); req1_a = $urandom; req1_b = $urandom;
            req1_tag = 4'($urandom_range(0, 15));
         end
         step("rand", r0, r1, g0, g1);
         last0 = g0;
         last1 = g1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) step("drain_end", r0, r1, g0, g1);
      check("end.empty", 64'(resp_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
